// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants, instruction field positions, opcode enum
//               and the decoded-instruction record for the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int DATA_W   = 24;
  localparam int REG_AW   = 2;
  localparam int NUM_REGS = 1 << REG_AW;

  // Instruction field positions
  localparam int OPC_MSB = 23;
  localparam int OPC_LSB = 20;
  localparam int RD_MSB  = 19;
  localparam int RD_LSB  = 18;
  localparam int RS_MSB  = 17;
  localparam int RS_LSB  = 16;
  localparam int RT_MSB  = 15;
  localparam int RT_LSB  = 14;
  localparam int IMM_MSB = 13;
  localparam int IMM_W   = 14;
  localparam int JT_MSB  = 17;
  localparam int JT_W    = 18;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_ADDI = 4'h4,
    OP_LW   = 4'h5,
    OP_SW   = 4'h6,
    OP_BEQ  = 4'h7,
    OP_J    = 4'h8,
    OP_NOP  = 4'hF
  } opcode_e;

  typedef struct packed {
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] imm;
    logic              uses_rs;
    logic              uses_rt;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              jump;
    logic              illegal;
  } decode_t;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_AW-1:0] idx);
    return NUM_REGS'(1) << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_decoder
// Description : Purely combinational split of a 24-bit instruction into
//               register indices, control flags and extended immediate.
// Ports       : instr (in, 24)  instruction word
//               dec   (out)     decoded record (decode_t)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decoder
  import mips_pkg::*;
(
  input  logic [DATA_W-1:0] instr,
  output decode_t           dec
);

  always_comb begin
    dec        = '0;
    dec.rd     = instr[RD_MSB:RD_LSB];
    dec.rs     = instr[RS_MSB:RS_LSB];
    dec.rt     = instr[RT_MSB:RT_LSB];
    dec.alu_op = instr[OPC_MSB:OPC_LSB];
    dec.imm    = {{(DATA_W-IMM_W){instr[IMM_MSB]}}, instr[IMM_MSB:0]};

    case (opcode_e'(instr[OPC_MSB:OPC_LSB]))
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        dec.uses_rs   = 1'b1;
        dec.uses_rt   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_ADDI: begin
        dec.uses_rs   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_LW: begin
        dec.uses_rs   = 1'b1;
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
      end
      OP_SW: begin
        dec.uses_rs   = 1'b1;
        dec.uses_rt   = 1'b1;
        dec.mem_write = 1'b1;
      end
      OP_BEQ: begin
        dec.uses_rs = 1'b1;
        dec.uses_rt = 1'b1;
        dec.branch  = 1'b1;
      end
      OP_J: begin
        // Jump target is the low 18 bits, zero-extended.
        dec.jump = 1'b1;
        dec.imm  = {{(DATA_W-JT_W){1'b0}}, instr[JT_MSB:0]};
      end
      OP_NOP: begin
      end
      default: begin
        // Unassigned opcodes behave as NOP but are flagged.
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Decode/issue stage feeding regFile. Valid/ready input
//               handshake, single output pipeline register and a 4-entry
//               scoreboard of pending register writes that stalls issue on
//               RAW/WAW hazards until writeback retires the producer.
// Config      : DECODE_WB_BYPASS_EN - when defined, a write retiring this
//               cycle (wb_valid/wb_reg) does not stall its consumer.
// Ports       : clock, reset_n (async, active low)
//               in_valid/in_ready/in_instr     upstream handshake
//               out_valid/out_ready            downstream handshake
//               read_reg_1/2, write_reg        register indices
//               reg_write, alu_op, imm         execute controls
//               mem_read, mem_write, branch, jump, illegal  flags
//               wb_valid/wb_reg                writeback retirement
//               flush                          discard output register
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
  import mips_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] read_reg_1,
  output logic [REG_AW-1:0] read_reg_2,
  output logic [REG_AW-1:0] write_reg,
  output logic              reg_write,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] imm,
  output logic              mem_read,
  output logic              mem_write,
  output logic              branch,
  output logic              jump,
  output logic              illegal,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_reg,
  input  logic              flush
);

  decode_t             w_dec;
  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pending_eff;
  logic [NUM_REGS-1:0] w_pending_nxt;
  logic                w_hazard;
  logic                w_transfer;

  logic                r_valid;
  logic [REG_AW-1:0]   r_rs;
  logic [REG_AW-1:0]   r_rt;
  logic [REG_AW-1:0]   r_rd;
  logic                r_reg_write;
  logic [3:0]          r_alu_op;
  logic [DATA_W-1:0]   r_imm;
  logic                r_mem_read;
  logic                r_mem_write;
  logic                r_branch;
  logic                r_jump;
  logic                r_illegal;

  instr_decoder u_instr_decoder (
    .instr (in_instr),
    .dec   (w_dec)
  );

`ifdef DECODE_WB_BYPASS_EN
  // A write retiring this cycle is already visible to the consumer.
  assign w_pending_eff = r_pending & ~({NUM_REGS{wb_valid}} & onehot(wb_reg));
`else
  assign w_pending_eff = r_pending;
`endif

  assign w_hazard = (w_dec.uses_rs   & w_pending_eff[w_dec.rs]) |
                    (w_dec.uses_rt   & w_pending_eff[w_dec.rt]) |
                    (w_dec.reg_write & w_pending_eff[w_dec.rd]);

  assign in_ready   = ~flush & ~w_hazard & (~r_valid | out_ready);
  assign w_transfer = in_valid & in_ready;

  // Scoreboard update order matters: clears first, then the issue set so
  // that a same-cycle set and clear of one bit leaves it set.
  always_comb begin
    w_pending_nxt = r_pending;
    if (wb_valid) begin
      w_pending_nxt = w_pending_nxt & ~onehot(wb_reg);
    end
    if (flush && r_valid && r_reg_write) begin
      w_pending_nxt = w_pending_nxt & ~onehot(r_rd);
    end
    if (w_transfer && w_dec.reg_write) begin
      w_pending_nxt = w_pending_nxt | onehot(w_dec.rd);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pending   <= '0;
      r_valid     <= 1'b0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_alu_op    <= '0;
      r_imm       <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_branch    <= 1'b0;
      r_jump      <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_transfer) begin
        r_valid     <= 1'b1;
        r_rs        <= w_dec.rs;
        r_rt        <= w_dec.rt;
        r_rd        <= w_dec.rd;
        r_reg_write <= w_dec.reg_write;
        r_alu_op    <= w_dec.alu_op;
        r_imm       <= w_dec.imm;
        r_mem_read  <= w_dec.mem_read;
        r_mem_write <= w_dec.mem_write;
        r_branch    <= w_dec.branch;
        r_jump      <= w_dec.jump;
        r_illegal   <= w_dec.illegal;
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_valid;
  assign read_reg_1 = r_rs;
  assign read_reg_2 = r_rt;
  assign write_reg  = r_rd;
  assign alu_op     = r_alu_op;
  assign imm        = r_imm;
  assign branch     = r_branch;
  assign jump       = r_jump;
  assign illegal    = r_illegal;
  // Side-effecting controls must never be seen without a valid instruction.
  assign reg_write  = r_valid & r_reg_write;
  assign mem_read   = r_valid & r_mem_read;
  assign mem_write  = r_valid & r_mem_write;

endmodule
`default_nettype wire
